// File: rtl/qpu_ifu_prefetch.sv
// Instruction fetch unit: PC generator issuing pipelined ICB reads to ITCM, a prefetch FIFO of
// {instr,pc} towards the EXU, flush redirect with stale-response discard, and halt req/ack.
module qpu_ifu_prefetch #(
    parameter int PC_W    = 12,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int OUTS    = 2,
    parameter int PC_STEP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PC_W-1:0]            pc_rtvec,
    output logic [PC_W-1:0]            inspect_pc,
    output logic                       icb_cmd_valid,
    input  logic                       icb_cmd_ready,
    output logic [ADDR_W-1:0]          icb_cmd_addr,
    input  logic                       icb_rsp_valid,
    output logic                       icb_rsp_ready,
    input  logic [DATA_W-1:0]          icb_rsp_rdata,
    output logic                       ifu_o_valid,
    input  logic                       ifu_o_ready,
    output logic [DATA_W-1:0]          ifu_o_ir,
    output logic [PC_W-1:0]            ifu_o_pc,
    input  logic                       flush_req,
    input  logic [PC_W-1:0]            flush_pc,
    output logic                       flush_ack,
    input  logic                       halt_req,
    output logic                       halt_ack,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int OUT_W = $clog2(OUTS) + 1;

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HALT} state_t;

    // Handshake rule on every channel: a transfer happens on a clock edge where valid && ready.
    state_t              state, state_next;
    logic [PC_W-1:0]     fetch_pc, rsp_pc;
    logic [OUT_W-1:0]    outstanding, discard_cnt;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    fifo_count;
    logic [DATA_W-1:0]   mem_ir [DEPTH];
    logic [PC_W-1:0]     mem_pc [DEPTH];
    logic                cmd_hs, rsp_hs, flush_hs, push, pop, drop;

    assign cmd_hs   = icb_cmd_valid && icb_cmd_ready;
    assign rsp_hs   = icb_rsp_valid && icb_rsp_ready && (outstanding != '0);
    assign flush_hs = flush_req && (state != ST_BOOT);
    assign pop      = ifu_o_valid && ifu_o_ready;
    assign drop     = rsp_hs && (discard_cnt != '0);
    // A flush clears the FIFO, so a live response arriving in the flush cycle is stale too.
    assign push     = rsp_hs && (discard_cnt == '0) && !flush_hs;

    assign icb_rsp_ready = !rst;
    assign flush_ack     = flush_hs;
    assign inspect_pc    = fetch_pc;
    assign icb_cmd_addr  = fetch_pc[ADDR_W-1:0];
    assign ifu_o_valid   = (fifo_count != '0);
    assign ifu_o_ir      = mem_ir[rd_ptr];
    assign ifu_o_pc      = mem_pc[rd_ptr];
    assign fifo_level    = fifo_count;

    always_comb begin
        state_next    = state;
        icb_cmd_valid = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_FETCH;
            ST_FETCH: begin
                // Credit: every issued read owns a FIFO slot before it is sent.
                icb_cmd_valid = !halt_req && !flush_req
                                && (int'(outstanding) < OUTS)
                                && (int'(outstanding) + int'(fifo_count) < DEPTH);
                if (halt_req && (outstanding == OUT_W'(rsp_hs)))
                    state_next = ST_HALT;
            end
            ST_HALT: if (!halt_req) state_next = ST_FETCH;
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            halt_ack    <= 1'b0;
            fetch_pc    <= '0;
            rsp_pc      <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ir[i] <= '0;
                mem_pc[i] <= '0;
            end
        end else begin
            state       <= state_next;
            halt_ack    <= (state == ST_HALT);
            outstanding <= outstanding + OUT_W'(cmd_hs) - OUT_W'(rsp_hs);

            if (state == ST_BOOT) begin
                fetch_pc <= pc_rtvec;
                rsp_pc   <= pc_rtvec;
            end else if (flush_hs) begin
                fetch_pc <= flush_pc;
                rsp_pc   <= flush_pc;
            end else begin
                if (cmd_hs) fetch_pc <= fetch_pc + PC_W'(PC_STEP);
                if (push)   rsp_pc   <= rsp_pc + PC_W'(PC_STEP);
            end

            // Every read still in flight after a flush is stale, including older stale ones.
            if (flush_hs)  discard_cnt <= outstanding - OUT_W'(rsp_hs);
            else if (drop) discard_cnt <= discard_cnt - OUT_W'(1);

            if (flush_hs) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    mem_ir[wr_ptr] <= icb_rsp_rdata;
                    mem_pc[wr_ptr] <= rsp_pc;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                fifo_count <= fifo_count + LVL_W'(push) - LVL_W'(pop);
            end
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(icb_rsp_valid && outstanding == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && int'(fifo_count) == DEPTH));

endmodule

// File: tb/tb_qpu_ifu_prefetch.sv
// Bench for qpu_ifu_prefetch: ITCM slave model with variable latency, EXU sink, and a scoreboard
// of {pc,ir} expected at the EXU port, covering flush, halt, stall, wrap and mid-stream reset.
module tb_qpu_ifu_prefetch;
    localparam int PC_W = 12, ADDR_W = 12, DATA_W = 32, DEPTH = 4, OUTS = 2, PC_STEP = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   pc_rtvec, inspect_pc, ifu_o_pc, flush_pc;
    logic              icb_cmd_valid, icb_cmd_ready, icb_rsp_valid, icb_rsp_ready;
    logic [ADDR_W-1:0] icb_cmd_addr;
    logic [DATA_W-1:0] icb_rsp_rdata, ifu_o_ir;
    logic              ifu_o_valid, ifu_o_ready, flush_req, flush_ack, halt_req, halt_ack;
    logic [$clog2(DEPTH):0] fifo_level;

    qpu_ifu_prefetch #(.PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .OUTS(OUTS), .PC_STEP(PC_STEP)) dut (
        .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec), .inspect_pc(inspect_pc),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
        .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir),
        .ifu_o_pc(ifu_o_pc), .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
        .halt_req(halt_req), .halt_ack(halt_ack), .fifo_level(fifo_level)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog sim time expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] itcm(input logic [11:0] a);
        return {8'hA5, a, ~a};
    endfunction

    // ---------------- ITCM slave model ----------------
    int rdy_rand = 0, lat_min = 1, lat_max = 1;
    logic [ADDR_W-1:0] pend_addr[$];
    int                pend_due[$];

    initial begin
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b0;
        icb_rsp_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            icb_cmd_ready = (rdy_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = itcm(pend_addr[0]);
            end else begin
                icb_rsp_valid = 1'b0;
                icb_rsp_rdata = $urandom;
            end
            @(negedge clk);
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (icb_rsp_valid) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (icb_cmd_valid && icb_cmd_ready) begin
                    pend_addr.push_back(icb_cmd_addr);
                    pend_due.push_back(cyc + $urandom_range(lat_min, lat_max));
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [43:0]     exp_q[$];
    logic [43:0]     e;
    logic [PC_W-1:0] next_addr = '0;
    int inflight = 0, live = 0, stale = 0, mstate = 0, cmd_cnt = 0, lvl;
    logic exp_ack = 1'b0, cmd_f, rsp_f;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_outs", {icb_cmd_valid, icb_rsp_ready, ifu_o_valid, flush_ack, halt_ack,
                                     icb_cmd_addr, inspect_pc, ifu_o_pc, fifo_level}, '0);
                check("reset_ir", ifu_o_ir, '0);
                exp_q.delete();
                next_addr = '0;
                inflight = 0; live = 0; stale = 0; mstate = 0; exp_ack = 1'b0;
            end else begin
                cmd_f = icb_cmd_valid && icb_cmd_ready;
                rsp_f = icb_rsp_valid;
                lvl = exp_q.size() - live;
                check("fifo_level", fifo_level, lvl);
                check("o_valid", ifu_o_valid, lvl != 0);
                check("inspect_pc", inspect_pc, next_addr);
                check("halt_ack", halt_ack, exp_ack);
                check("rsp_ready", icb_rsp_ready, 1);
                if (ifu_o_valid && ifu_o_ready) begin
                    if (exp_q.size() == 0) check("pop_empty", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("ifu_out", {ifu_o_pc, ifu_o_ir}, e);
                    end
                end
                check("flush_ack", flush_ack, flush_req && mstate != 0);
                exp_ack = (mstate == 2);
                if (mstate == 0) begin
                    check("boot_no_cmd", icb_cmd_valid, 0);
                    next_addr = pc_rtvec;
                    mstate = 1;
                end else begin
                    if (icb_cmd_valid)
                        check("credit", (inflight < OUTS) && (inflight + lvl < DEPTH), 1);
                    if (halt_req || flush_req || mstate == 2)
                        check("no_cmd", icb_cmd_valid, 0);
                    if (rsp_f) begin
                        if (stale > 0) stale--;
                        else if (live > 0) live--;
                    end
                    if (flush_req) begin
                        exp_q.delete();
                        stale += live;
                        live = 0;
                        next_addr = flush_pc;
                    end else if (cmd_f) begin
                        check("cmd_addr", icb_cmd_addr, next_addr);
                        exp_q.push_back({next_addr, itcm(next_addr)});
                        next_addr = next_addr + PC_W'(PC_STEP);
                        live++;
                        cmd_cnt++;
                    end
                    inflight = inflight + int'(cmd_f) - int'(rsp_f);
                    if (mstate == 1 && halt_req && inflight == 0) mstate = 2;
                    else if (mstate == 2 && !halt_req) mstate = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_inflight(input string tag, input int n, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (inflight >= n) ok = 1;
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_out_valid(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (ifu_o_valid) ok = 1;
            else step(1);
        end
        check(tag, ok, 1);
    endtask

    task automatic pulse_flush(input logic [PC_W-1:0] pc);
        flush_req = 1'b1;
        flush_pc  = pc;
        step(1);
        flush_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int c0;
    bit found;

    initial begin
        rst = 1'b1; pc_rtvec = 12'h100; ifu_o_ready = 1'b1;
        flush_req = 1'b0; flush_pc = '0; halt_req = 1'b0;
        step(3);
        rst = 1'b0;
        step(40);                                     // sequential stream from 0x100

        // EXU stalled: credit limits total issue to DEPTH
        ifu_o_ready = 1'b0; rst = 1'b1; step(2); rst = 1'b0;
        c0 = cmd_cnt;
        step(20);
        check("stall_cmds", cmd_cnt - c0, 4);
        check("stall_level", fifo_level, 4);
        check("stall_cmd_valid", icb_cmd_valid, 0);
        ifu_o_ready = 1'b1; step(1); ifu_o_ready = 1'b0;
        step(10);
        check("stall_refill_cmds", cmd_cnt - c0, 5);
        check("stall_refill_level", fifo_level, 4);
        ifu_o_ready = 1'b1;

        // Latency 3, flush with two reads in flight
        lat_min = 3; lat_max = 3;
        step(10);
        wait_inflight("flush2_wait", 2, 20);
        pulse_flush(12'h040);
        wait_out_valid("flush2_out_wait", 30);
        check("flush2_first_pc", ifu_o_pc, 12'h040);
        check("flush2_first_ir", ifu_o_ir, itcm(12'h040));

        // Flush in the same cycle as a response and a pop
        lat_min = 1; lat_max = 1;
        step(10);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1);
            if (icb_rsp_valid && ifu_o_valid) found = 1;
        end
        check("flush_rsp_pop_found", found, 1);
        pulse_flush(12'h200);
        check("flush_same_level", fifo_level, 0);
        check("flush_same_valid", ifu_o_valid, 0);
        wait_out_valid("flush_same_out_wait", 30);
        check("flush_same_first_pc", ifu_o_pc, 12'h200);

        // Halt with two reads in flight, then resume
        lat_min = 3; lat_max = 3;
        step(10);
        wait_inflight("halt_wait_inflight", 2, 20);
        halt_req = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (halt_ack) found = 1;
        end
        check("halt_ack_rise", found, 1);
        step(5);
        check("halted_no_cmd", icb_cmd_valid, 0);
        halt_req = 1'b0;
        step(2);
        check("halt_ack_fall", halt_ack, 0);
        step(20);

        // PC wrap at 0xFFF
        lat_min = 1; lat_max = 1;
        pulse_flush(12'hFFD);
        step(15);

        // Mid-stream reset with a new reset vector
        pc_rtvec = 12'h300;
        rst = 1'b1;
        #1;
        check("async_reset_outs", {icb_cmd_valid, ifu_o_valid, halt_ack, inspect_pc, fifo_level}, '0);
        step(2);
        rst = 1'b0;
        step(20);

        // Randomised traffic
        rdy_rand = 1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            ifu_o_ready = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 39) == 0);
            flush_pc = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 49) == 0) halt_req = ~halt_req;
            step(1);
        end
        flush_req = 1'b0;

        // Drain: halt fetching and empty the FIFO
        rdy_rand = 0; ifu_o_ready = 1'b1; halt_req = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (halt_ack && fifo_level == 0) found = 1;
        end
        check("drain_done", found, 1);
        check("drain_exp_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
